// File: rtl/spectrum_accumulator_pkg.sv
// Shared types and widths for the spectrum accumulator.
package spectrum_accumulator_pkg;

    localparam int unsigned BINS_DEF     = 256;
    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned AVG_W        = 4;
    localparam int unsigned AVG_LOG2_MAX = 8;
    localparam int unsigned FCNT_W       = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // One accepted sample waiting for its SRAM write slot
    typedef struct packed {
        logic                accum;
        logic [ADDR_W-1:0]   addr;
        logic [SAMPLE_W-1:0] sample;
    } pend_t;

    // Frames-per-run exponent saturates at the largest supported run
    function automatic logic [AVG_W-1:0] clamp_avg(input logic [AVG_W-1:0] a);
        return (a > AVG_W'(AVG_LOG2_MAX)) ? AVG_W'(AVG_LOG2_MAX) : a;
    endfunction

endpackage

// File: rtl/spec_acc_pipe.sv
// Read/add/write stage: issues the SRAM read on transfer, writes the sum one cycle later.
module spec_acc_pipe
    import spectrum_accumulator_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                xfer_i,
    input  logic                accum_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [DATA_W-1:0]   rd_data_i,
    output logic                rd_en_c,
    output logic [ADDR_W-1:0]   rd_addr_c,
    output logic                wr_en_c,
    output logic [ADDR_W-1:0]   wr_addr_c,
    output logic [DATA_W-1:0]   wr_data_c
);

    logic              pend_valid_q, pend_valid_d;
    pend_t             pend_q, pend_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_W-1:0] operand;

    // Read issue, forwarding mux and write data for the pending sample
    always_comb begin
        rd_en_c   = xfer_i && accum_i;
        rd_addr_c = rd_en_c ? addr_i : '0;
        operand   = fwd_hit_q ? fwd_data_q : rd_data_i;
        wr_en_c   = pend_valid_q;
        wr_addr_c = '0;
        wr_data_c = '0;
        if (pend_valid_q) begin
            wr_addr_c = pend_q.addr;
            wr_data_c = pend_q.accum ? (operand + DATA_W'(pend_q.sample))
                                     : DATA_W'(pend_q.sample);
        end
    end

    // Capture the next pending write; SRAM reads are read-first, so a same-cycle
    // write to the read address must be bypassed into next cycle's operand
    always_comb begin
        pend_valid_d = xfer_i;
        pend_d       = pend_q;
        if (xfer_i) begin
            pend_d.accum  = accum_i;
            pend_d.addr   = addr_i;
            pend_d.sample = sample_i;
        end
        fwd_hit_d  = rd_en_c && pend_valid_q && (pend_q.addr == addr_i);
        fwd_data_d = fwd_hit_d ? wr_data_c : fwd_data_q;
    end

    // Pipeline registers; reset drops any in-flight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

endmodule

// File: rtl/spectrum_accumulator.sv
// Averages 2^avg_log2 spectrum frames into an external SRAM, one sample per cycle.
module spectrum_accumulator
    import spectrum_accumulator_pkg::*;
#(
    parameter int unsigned BINS = BINS_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                start,
    input  logic [AVG_W-1:0]    avg_log2,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_last,
    output logic [ADDR_W-1:0]   W0_addr,
    output logic                W0_en,
    output logic                W0_clk,
    output logic [DATA_W-1:0]   W0_data,
    output logic [ADDR_W-1:0]   R0_addr,
    output logic                R0_en,
    output logic                R0_clk,
    input  logic [DATA_W-1:0]   R0_data,
    output logic                busy,
    output logic                done,
    output logic                frame_err,
    output logic [FCNT_W-1:0]   frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bin_q, bin_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              frame_err_q, frame_err_d;
    logic [AVG_W-1:0]  avg_q, avg_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;

    logic              xfer, last_bin, frame_end, run_start, accum;
    logic [FCNT_W-1:0] frame_cnt_inc, frames_tgt;

    assign xfer          = in_valid && in_ready_q;
    assign last_bin      = (bin_q == LAST_BIN);
    assign frame_end     = xfer && (in_last || last_bin);
    assign frame_cnt_inc = frame_cnt_q + FCNT_W'(1);
    assign frames_tgt    = FCNT_W'(1) << avg_q;
    assign run_start     = (state_q == ST_IDLE) && start && !done_q;
    assign accum         = (frame_cnt_q != '0);

    // State and control registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            frame_cnt_q <= '0;
            frame_err_q <= 1'b0;
            avg_q       <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            frame_cnt_q <= frame_cnt_d;
            frame_err_q <= frame_err_d;
            avg_q       <= avg_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state: run while frames remain, one flush cycle for the last write
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run_start) state_d = ST_ACCUM;
            ST_ACCUM: if (frame_end && (frame_cnt_inc == frames_tgt)) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bin/frame counters, framing error and registered status outputs
    always_comb begin
        bin_d       = bin_q;
        frame_cnt_d = frame_cnt_q;
        frame_err_d = frame_err_q;
        avg_d       = avg_q;
        done_d      = (state_q == ST_FLUSH);
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_ACCUM);
        if (run_start) begin
            bin_d       = '0;
            frame_cnt_d = '0;
            frame_err_d = 1'b0;
            avg_d       = clamp_avg(avg_log2);
        end
        if (xfer) begin
            if (frame_end) begin
                bin_d       = '0;
                frame_cnt_d = frame_cnt_inc;
                if (in_last != last_bin) frame_err_d = 1'b1;
            end else begin
                bin_d = bin_q + ADDR_W'(1);
            end
        end
    end

    spec_acc_pipe u_pipe (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .xfer_i    (xfer),
        .accum_i   (accum),
        .addr_i    (bin_q),
        .sample_i  (in_data),
        .rd_data_i (R0_data),
        .rd_en_c   (R0_en),
        .rd_addr_c (R0_addr),
        .wr_en_c   (W0_en),
        .wr_addr_c (W0_addr),
        .wr_data_c (W0_data)
    );

    assign W0_clk    = wb_clk_i;
    assign R0_clk    = wb_clk_i;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
